// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch stage: holds the architectural PC, fetches one 32-bit word
// per transaction over a req/ack memory port, hands {inst, pc} downstream with
// valid/ready, and loads the next PC from dnpc on acceptance. A misaligned dnpc
// or an unacknowledged fetch lasting TIMEOUT cycles halts the stage in a sticky
// error state that only reset clears.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   halt            blocks starting a new fetch (in-flight fetch completes)
//   imem_req/addr   fetch request and address (address == pc)
//   imem_ack/rdata  fetch completion and instruction word
//   inst_valid/ready downstream handshake; inst/pc payload
//   dnpc            next PC from execute, sampled on acceptance
//   fetch_err       sticky error flag; err_cause 01 misaligned, 10 timeout
//   inst_cnt        number of accepted instructions
module ysyx_220053_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] pc,
   input  logic [63:0] dnpc,
   output logic        fetch_err,
   output logic [1:0]  err_cause,
   output logic [63:0] inst_cnt
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned PC_W   = 64;
   localparam int unsigned INST_W = 32;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_ALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TMO   = 2'b10;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_ERR   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic [CNT_W-1:0]    tmo_q, tmo_d;
   logic [PC_W-1:0]     icnt_q, icnt_d;
   logic [1:0]          cause_q, cause_d;
   logic                req_q, req_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;

   // State and datapath registers; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         tmo_q   <= '0;
         icnt_q  <= '0;
         cause_q <= CAUSE_NONE;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         tmo_q   <= tmo_d;
         icnt_q  <= icnt_d;
         cause_q <= cause_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; handshake outputs are registered from the next state so
   // neither depends combinationally on ack/ready.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      tmo_d   = tmo_q;
      icnt_d  = icnt_q;
      cause_d = cause_q;

      unique case (state_q)
         S_FETCH: begin
            if (!halt) state_d = S_WAIT;
         end
         S_WAIT: begin
            // An ack in the last allowed cycle wins over the timeout.
            if (imem_ack) begin
               inst_d  = imem_rdata;
               tmo_d   = '0;
               state_d = S_VALID;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
               if (tmo_d == CNT_W'(TIMEOUT)) begin
                  state_d = S_ERR;
                  cause_d = CAUSE_TMO;
               end
            end
         end
         S_VALID: begin
            if (inst_ready) begin
               icnt_d = icnt_q + PC_W'(1);
               if (dnpc[1:0] == 2'b00) begin
                  pc_d    = dnpc;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_ERR;
                  cause_d = CAUSE_ALIGN;
               end
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase

      req_d   = (state_d == S_WAIT);
      valid_d = (state_d == S_VALID);
      err_d   = (state_d == S_ERR);
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign pc         = pc_q;
   assign fetch_err  = err_q;
   assign err_cause  = cause_q;
   assign inst_cnt   = icnt_q;

endmodule

// File: doc/ysyx_220053_ifu.md
Name: ysyx_220053_ifu

Overview:
Instruction fetch stage sitting directly upstream of the execute stage. Holds the architectural PC and fetches one 32-bit instruction per transaction over a variable-latency req/ack instruction-memory port. Presents {inst, pc} to the downstream stage with a valid/ready handshake. On acceptance, loads the next PC from the execute stage's dnpc output. Detects misaligned next-PC and fetch timeout, and halts in a sticky error state.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles imem_req may stay unacknowledged before error (8-bit counter)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
halt  input  1  when 1, no new fetch is started; an in-flight request still completes
imem_req  output  1  fetch request, held until acknowledged
imem_addr  output  64  fetch address; equals pc while imem_req=1
imem_ack  input  1  transfer completes in any cycle where imem_req=1 and imem_ack=1
imem_rdata  input  32  instruction word; valid in the ack cycle only
inst_valid  output  1  inst/pc are valid for downstream
inst_ready  input  1  downstream accepts in cycle where inst_valid=1 and inst_ready=1
inst  output  32  latched instruction
pc  output  64  PC of inst (architectural PC)
dnpc  input  64  next PC from execute stage; sampled only in the accept cycle
fetch_err  output  1  sticky error flag
err_cause  output  2  01 = misaligned dnpc, 10 = imem timeout, 00 = none
inst_cnt  output  64  count of accepted instructions

Behaviour:
- Reset (rst=0, asynchronous) values:
  - pc=RESET_PC, state=FETCH, imem_req=0, inst_valid=0, inst=0
  - fetch_err=0, err_cause=00, inst_cnt=0, timeout counter=0
  - An outstanding request is abandoned; imem_req drops immediately.
- States: FETCH, WAIT, VALID, ERR.
- FETCH:
  - imem_req=0.
  - halt=0: go to WAIT next cycle.
  - halt=1: stay.
- WAIT:
  - imem_req=1, imem_addr=pc, both stable until ack.
  - On imem_ack=1: inst<=imem_rdata, go to VALID, clear the timeout counter.
  - Otherwise the counter increments.
  - Counter reaching TIMEOUT with no ack: go to ERR, err_cause=10.
  - The ack cycle takes priority over timeout.
- VALID:
  - inst_valid=1; inst and pc held stable while inst_ready=0.
  - On inst_valid&inst_ready:
    - inst_cnt+=1 (wraps at 2^64).
    - If dnpc[1:0]==00: pc<=dnpc, go to FETCH.
    - Otherwise: pc unchanged, go to ERR, err_cause=01.
  - halt is ignored in VALID.
- ERR:
  - imem_req=0, inst_valid=0, fetch_err=1.
  - pc and err_cause frozen; exits only via reset.
- Latency:
  - Minimum 2 cycles from entering WAIT to inst_valid: ack in the first WAIT cycle gives inst_valid the next cycle.
  - Minimum 3 cycles per instruction: FETCH, WAIT, VALID.
- inst_valid never depends combinationally on inst_ready. imem_req never depends combinationally on imem_ack.
- pc arithmetic is full 64-bit. No sign or width adjustment: dnpc is taken verbatim.

Test Plan:
- Reset release, halt=0, imem_ack same cycle as first req, imem_rdata=0x00000013 -> imem_addr=0x80000000 during req; inst_valid=1 next cycle with inst=0x00000013, pc=0x80000000.
- Accept with dnpc=0x80000004 and 3-cycle ack latency -> imem_req held 3 cycles with imem_addr=0x80000004, stable; inst_cnt=1 then 2 after second accept.
- inst_ready=0 for 5 cycles in VALID -> inst/pc unchanged, no new imem_req; accept on cycle 6 advances pc to dnpc.
- Accept with dnpc=0x80000006 -> fetch_err=1, err_cause=01, pc stays 0x80000000, imem_req stays 0 forever.
- imem_ack never asserted, TIMEOUT=4 -> fetch_err=1, err_cause=10 after the timeout expires; ack on the final cycle instead -> normal VALID, no error.
- Drive rst=0 mid-WAIT, asynchronous to clk -> imem_req drops without waiting for an edge; after release, pc=0x80000000 and inst_cnt=0. Separately: halt=1 in FETCH keeps imem_req=0 indefinitely.
